// File: rtl/conv_pe_lb.sv
// KxK streaming convolution PE: line buffers, KxK window, weight store, 3-stage MAC pipeline.
// Optional output ReLU when CONV_PE_RELU_EN is defined.
module conv_pe_lb #(
  parameter  int WIDTH = 9,
  parameter  int K     = 3,
  parameter  int IMG_W = 10,
  parameter  int IMG_H = 10,
  localparam int ACC_W = 2*WIDTH + $clog2(K*K)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    weight_valid,
  input  logic signed [WIDTH-1:0] weight_in,
  input  logic                    start,
  input  logic                    data_valid,
  input  logic signed [WIDTH-1:0] data_in,
  output logic                    weights_loaded,
  output logic                    busy,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] data_out,
  output logic                    frame_done
);

  localparam int NW   = K*K;
  localparam int NPIX = IMG_W*IMG_H;
  localparam int MW   = 2*WIDTH;
  localparam int WCW  = $clog2(NW);
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW   = $clog2(NPIX + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_nxt;
  logic [1:0]     dcnt;
  logic           accept, wr_en, go, complete, last_pix;
  logic [WCW-1:0] wcnt;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [PW-1:0]  pcnt;

  logic signed [WIDTH-1:0] weight_buf [NW];
  logic signed [WIDTH-1:0] lb         [K-1][IMG_W];
  logic signed [WIDTH-1:0] win        [K][K];
  logic signed [WIDTH-1:0] win_nxt    [K][K];
  logic signed [MW-1:0]    prod       [NW];
  logic signed [MW-1:0]    mreg       [NW];
  logic signed [ACC_W-1:0] sum, sreg, res;
  logic                    v1, v2;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && weights_loaded) state_nxt = RUN;
      RUN:     if (accept && last_pix)      state_nxt = DRAIN;
      DRAIN:   if (dcnt == 2'd2)            state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy   = (state != IDLE);
    accept = (state == RUN) && data_valid;
    wr_en  = (state == IDLE) && weight_valid;
    go     = (state == IDLE) && start && weights_loaded;
  end

  assign last_pix = (pcnt == PW'(NPIX - 1));
  assign complete = (row >= RW'(K - 1)) && (col >= CW'(K - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt       <= '0;
      frame_done <= 1'b0;
    end else begin
      dcnt       <= (state == DRAIN) ? dcnt + 2'd1 : '0;
      frame_done <= (state == DRAIN) && (dcnt == 2'd2);
    end
  end

  // Weight store; weights_loaded is sampled before this cycle's write by the start logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt           <= '0;
      weights_loaded <= 1'b0;
      for (int unsigned i = 0; i < NW; i++) weight_buf[i] <= '0;
    end else if (wr_en) begin
      weight_buf[wcnt] <= weight_in;
      if (wcnt == WCW'(NW - 1)) begin
        wcnt           <= '0;
        weights_loaded <= 1'b1;
      end else begin
        wcnt <= wcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      col  <= '0;
      pcnt <= '0;
    end else if (go) begin
      row  <= '0;
      col  <= '0;
      pcnt <= '0;
    end else if (accept) begin
      pcnt <= pcnt + 1'b1;
      if (col == CW'(IMG_W - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Row K-1 of the window takes the new pixel; row r above it takes the tail of line buffer K-2-r.
  always_comb begin
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K - 1; c++) win_nxt[r][c] = win[r][c+1];
      if (r == K - 1) win_nxt[r][K-1] = data_in;
      else            win_nxt[r][K-1] = lb[K-2-r][IMG_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < K - 1; i++)
        for (int unsigned j = 0; j < IMG_W; j++) lb[i][j] <= '0;
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned c = 0; c < K; c++) win[r][c] <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < K - 1; i++) begin
        lb[i][0] <= (i == 0) ? data_in : lb[i-1][IMG_W-1];
        for (int unsigned j = 1; j < IMG_W; j++) lb[i][j] <= lb[i][j-1];
      end
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned c = 0; c < K; c++) win[r][c] <= win_nxt[r][c];
    end
  end

  // Stage 1 multiplies the window as it stands after this cycle's shift, keeping latency at 3.
  always_comb begin
    for (int unsigned r = 0; r < K; r++)
      for (int unsigned c = 0; c < K; c++)
        prod[r*K+c] = MW'(weight_buf[r*K+c]) * MW'(win_nxt[r][c]);
  end

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NW; i++) sum = sum + ACC_W'(mreg[i]);
  end

`ifdef CONV_PE_RELU_EN
  assign res = sreg[ACC_W-1] ? '0 : sreg;
`else
  assign res = sreg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NW; i++) mreg[i] <= '0;
      sreg      <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      for (int unsigned i = 0; i < NW; i++) mreg[i] <= prod[i];
      sreg      <= sum;
      v1        <= accept && complete;
      v2        <= v1;
      out_valid <= v2;
      if (v2) data_out <= res;
    end
  end

endmodule
